// File: rtl/alu_operand_sel.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_sel
//  Description : Buffered ALU operand selector. Picks one of NUM_SRC source
//                channels, applies an operand mode (pass / invert / zero /
//                hold-last) and delivers the result through a 2-entry FIFO
//                with a valid/ready handshake. Out-of-range selects yield a
//                zero operand flagged with op_err and are counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sel #(
   parameter int DATA_W  = 18,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*DATA_W-1:0] src_bus,
   input  logic [SEL_W-1:0]          sel,
   input  logic [1:0]                mode,
   input  logic                      req_valid,
   output logic                      req_ready,
   output logic                      op_valid,
   input  logic                      op_ready,
   output logic [DATA_W-1:0]         op_data,
   output logic                      op_err,
   output logic [7:0]                err_cnt
);

   localparam logic [SEL_W:0] c_NUM_SRC  = (SEL_W+1)'(NUM_SRC);
   localparam logic [1:0]     c_MODE_PASS = 2'b00;
   localparam logic [1:0]     c_MODE_INV  = 2'b01;
   localparam logic [1:0]     c_MODE_ZERO = 2'b10;
   localparam logic [1:0]     c_MODE_HOLD = 2'b11;

   // Source channels unpacked into an array for indexed selection
   logic [DATA_W-1:0] w_src [NUM_SRC];

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
         assign w_src[gi] = src_bus[gi*DATA_W +: DATA_W];
      end
   endgenerate

   logic [DATA_W-1:0] w_chan;
   logic              w_in_range;
   logic [DATA_W-1:0] w_res_data;
   logic              w_res_err;
   logic              w_push;
   logic              w_pop;

   // FIFO storage: entry 0 is always the head
   logic [DATA_W-1:0] r_data0;
   logic [DATA_W-1:0] r_data1;
   logic              r_err0;
   logic              r_err1;
   logic [1:0]        r_count;
   logic [DATA_W-1:0] r_last;
   logic [7:0]        r_err_cnt;

   assign w_in_range = ({1'b0, sel} < c_NUM_SRC);

   // Channel mux; only matching in-range indices can drive the result
   always_comb begin
      w_chan = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) begin
            w_chan = w_src[i];
         end
      end
   end

   // Operand mode and range check; hold mode ignores sel entirely
   always_comb begin
      w_res_data = '0;
      w_res_err  = 1'b0;
      if (mode == c_MODE_HOLD) begin
         w_res_data = r_last;
      end else if (!w_in_range) begin
         w_res_err = 1'b1;
      end else begin
         case (mode)
            c_MODE_PASS: w_res_data = w_chan;
            c_MODE_INV:  w_res_data = ~w_chan;
            c_MODE_ZERO: w_res_data = '0;
            default:     w_res_data = '0;
         endcase
      end
   end

   // Handshake only depends on registered occupancy, never on op_ready
   assign req_ready = (r_count != 2'd2);
   assign op_valid  = (r_count != 2'd0);
   assign w_push    = req_valid && req_ready;
   assign w_pop     = op_valid && op_ready;

   assign op_data = r_data0;
   assign op_err  = r_err0;
   assign err_cnt = r_err_cnt;

   // FIFO update, hold register and saturating error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data0   <= '0;
         r_data1   <= '0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
         r_count   <= 2'd0;
         r_last    <= '0;
         r_err_cnt <= 8'd0;
      end else begin
         if (w_push) begin
            r_last <= w_res_data;
            if (w_res_err && (r_err_cnt != 8'hFF)) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_data0 <= w_res_data;
                  r_err0  <= w_res_err;
               end else begin
                  r_data1 <= w_res_data;
                  r_err1  <= w_res_err;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               // Leave a stale head in place when draining the last entry
               if (r_count == 2'd2) begin
                  r_data0 <= r_data1;
                  r_err0  <= r_err1;
               end
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Only reachable with one entry: the new result replaces the head
               r_data0 <= w_res_data;
               r_err0  <= w_res_err;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
